// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and source encoding for the register-file writeback arbiter
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter holding the last-grant register
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  src_e last_grant_q, last_grant_d;

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant_q;
    // Under contention the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = (last_grant_q == SRC_LD) ? 2'b01 : 2'b10;
    end
    if (accept && gnt[1]) begin
      last_grant_d = SRC_LD;
    end else if (accept && gnt[0]) begin
      last_grant_d = SRC_ALU;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= SRC_LD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load writeback
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              finish_flag,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic              halted,
  output logic [31:0]       wb_count
);

  logic              stg_valid_q, stg_valid_d;
  logic [ADDR_W-1:0] stg_rd_q, stg_rd_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d;
  logic              halted_q, halted_d;
  logic [31:0]       wb_count_q, wb_count_d;

  logic       halt_now;
  logic       accept;
  logic [1:0] gnt;

  // finish_flag blocks writes in the very cycle it is seen, before it is registered.
  assign halt_now = halted_q | finish_flag | reset;
  assign accept   = (alu_valid | ld_valid) & ~halt_now;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({ld_valid, alu_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign alu_ready = gnt[0] & ~halt_now;
  assign ld_ready  = gnt[1] & ~halt_now;
  assign RegWrite  = stg_valid_q & ~halt_now;
  assign RD        = stg_rd_q;
  assign WriteData = stg_data_q;
  assign fwd1_hit  = RegWrite & (Read1 == stg_rd_q);
  assign fwd2_hit  = RegWrite & (Read2 == stg_rd_q);
  assign halted    = halted_q;
  assign wb_count  = wb_count_q;

  always_comb begin
    stg_valid_d = 1'b0;
    stg_rd_d    = stg_rd_q;
    stg_data_d  = stg_data_q;
    halted_d    = halted_q | finish_flag;
    wb_count_d  = wb_count_q + 32'(RegWrite);
    if (accept) begin
      stg_rd_d    = gnt[1] ? ld_rd : alu_rd;
      stg_data_d  = gnt[1] ? ld_data : alu_data;
      stg_valid_d = (stg_rd_d != ADDR_W'(REG_ZERO));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_rd_q    <= '0;
      stg_data_q  <= '0;
      halted_q    <= 1'b0;
      wb_count_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_rd_q    <= stg_rd_d;
      stg_data_q  <= stg_data_d;
      halted_q    <= halted_d;
      wb_count_q  <= wb_count_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        finish_flag = 1'b0;
  logic [4:0]  RD;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  Read1 = '0;
  logic [4:0]  Read2 = '0;
  logic        fwd1_hit, fwd2_hit, halted;
  logic [31:0] wb_count;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .finish_flag(finish_flag),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .halted(halted), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who has priority under contention, what write is pending, halt and count.
  bit          m_alu_turn = 1'b1;
  bit          m_pend = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  bit          m_halted = 1'b0;
  int unsigned m_count = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        m_alu_turn = 1'b1;
        m_pend     = 1'b0;
        m_halted   = 1'b0;
        m_count    = 0;
      end else begin
        bit blocked, alu_wins, ld_wins, writes;
        blocked  = m_halted || finish_flag;
        alu_wins = alu_valid && (!ld_valid || m_alu_turn);
        ld_wins  = ld_valid && !alu_wins;
        writes   = m_pend && !blocked;
        chk("m_alu_ready", 32'(alu_ready), 32'(alu_wins && !blocked));
        chk("m_ld_ready", 32'(ld_ready), 32'(ld_wins && !blocked));
        chk("m_regwrite", 32'(RegWrite), 32'(writes));
        chk("m_halted", 32'(halted), 32'(m_halted));
        chk("m_wb_count", wb_count, m_count);
        chk("m_fwd1", 32'(fwd1_hit), 32'(writes && Read1 == m_rd));
        chk("m_fwd2", 32'(fwd2_hit), 32'(writes && Read2 == m_rd));
        if (writes) begin
          chk("m_rd", 32'(RD), 32'(m_rd));
          chk("m_wdata", WriteData, m_data);
          m_count++;
        end
        if (finish_flag) m_halted = 1'b1;
        if ((alu_wins || ld_wins) && !blocked) begin
          m_rd       = alu_wins ? alu_rd : ld_rd;
          m_data     = alu_wins ? alu_data : ld_data;
          m_pend     = (m_rd != 5'd0);
          m_alu_turn = ld_wins;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
  endtask

  logic [31:0] saved_count;
  logic [4:0]  exp_rd_seq [4];

  initial begin
    exp_rd_seq[0] = 5'd3; exp_rd_seq[1] = 5'd4; exp_rd_seq[2] = 5'd3; exp_rd_seq[3] = 5'd4;
    #3;
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_rd", 32'(RD), 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", wb_count, 0);
    chk("rst_ready", {30'd0, alu_ready, ld_ready}, 0);
    chk("rst_hits", {30'd0, fwd1_hit, fwd2_hit}, 0);
    step();
    reset = 1'b0;

    // single ALU write
    step();
    drive(1, 5'd7, 32'h1234, 0, 0, 0);
    #1 chk("alu1_ready", 32'(alu_ready), 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("alu1_we", 32'(RegWrite), 1);
    chk("alu1_rd", 32'(RD), 7);
    chk("alu1_wdata", WriteData, 32'h1234);
    step();
    #1 chk("alu1_count", wb_count, 1);

    // forwarding from a pending load write
    step();
    drive(0, 0, 0, 1, 5'd5, 32'h55);
    #1 chk("fwd_ld_ready", 32'(ld_ready), 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    Read1 = 5'd5; Read2 = 5'd6;
    #1 chk("fwd1_on", 32'(fwd1_hit), 1);
    chk("fwd2_off", 32'(fwd2_hit), 0);
    step();
    #1 chk("fwd_after", {30'd0, fwd1_hit, fwd2_hit}, 0);
    Read1 = 0; Read2 = 0;

    // continuous contention: ALU, LD, ALU, LD
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1, 5'd3, 32'h300 + i, 1, 5'd4, 32'h400 + i);
      #1 chk("cont_alu_gnt", 32'(alu_ready), 32'(i % 2 == 0));
      chk("cont_ld_gnt", 32'(ld_ready), 32'(i % 2 == 1));
      if (i > 0) chk("cont_rd", 32'(RD), 32'(exp_rd_seq[i-1]));
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("cont_rd_last", 32'(RD), 32'(exp_rd_seq[3]));

    // same rd from both sources: ALU value first, load value final
    step();
    drive(1, 5'd9, 32'hA, 1, 5'd9, 32'hB);
    #1 chk("same_alu_first", 32'(alu_ready), 1);
    step();
    drive(0, 0, 0, 1, 5'd9, 32'hB);
    #1 chk("same_ld_second", 32'(ld_ready), 1);
    chk("same_wdata_a", WriteData, 32'hA);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("same_wdata_b", WriteData, 32'hB);
    chk("same_rd", 32'(RD), 9);

    // x0 write is accepted but never written
    step();
    saved_count = wb_count;
    drive(1, 5'd0, 32'hFF, 0, 0, 0);
    #1 chk("x0_ready", 32'(alu_ready), 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("x0_no_we", 32'(RegWrite), 0);
    step();
    #1 chk("x0_count", wb_count, saved_count);

    // halt while a write is staged
    step();
    drive(1, 5'd12, 32'h77, 0, 0, 0);
    step();
    finish_flag = 1'b1;
    drive(1, 5'd13, 32'h88, 1, 5'd14, 32'h99);
    #1 chk("halt_no_we", 32'(RegWrite), 0);
    chk("halt_ready0", {30'd0, alu_ready, ld_ready}, 0);
    step();
    finish_flag = 1'b0;
    #1 chk("halt_sticky", 32'(halted), 1);
    chk("halt_ready1", {30'd0, alu_ready, ld_ready}, 0);
    repeat (3) step();
    #1 chk("halt_still", 32'(halted), 1);
    chk("halt_still_ready", {30'd0, alu_ready, ld_ready}, 0);

    // asynchronous reset mid-cycle, then resume
    step();
    reset = 1'b1;
    #1 chk("mid_rst_halted", 32'(halted), 0);
    chk("mid_rst_count", wb_count, 0);
    chk("mid_rst_outs", {RegWrite, alu_ready, ld_ready, fwd1_hit, fwd2_hit}, 0);
    chk("mid_rst_rd", 32'(RD), 0);
    step();
    reset = 1'b0;
    drive(1, 5'd1, 32'h99, 0, 0, 0);
    #1 chk("resume_ready", 32'(alu_ready), 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("resume_we", 32'(RegWrite), 1);
    chk("resume_wdata", WriteData, 32'h99);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
